// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared types and defaults for the write-back arbiter
package wb_pkg;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LSU = 1'b1
  } src_e;

  localparam int WB_DATA_W_DEF = 64;
  localparam int WB_ADDR_W_DEF = 7;
  localparam int GP_LO_DEF     = 4;
  localparam int GP_HI_DEF     = 27;

  typedef struct packed {
    logic                     valid;
    logic [WB_ADDR_W_DEF-1:0] rd;
    logic [WB_DATA_W_DEF-1:0] data;
  } slot_t;

endpackage

// File: rtl/wb_slot.sv
// rtl/wb_slot.sv - one-entry result holding slot with valid/ready handshake
module wb_slot #(
  parameter int DATA_WIDTH          = 64,
  parameter int DATA_REG_ADDR_WIDTH = 7
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [DATA_REG_ADDR_WIDTH-1:0] in_rd,
  input  logic [DATA_WIDTH-1:0]          in_data,
  input  logic                           clear,
  output logic                           full,
  output logic [DATA_REG_ADDR_WIDTH-1:0] rd,
  output logic [DATA_WIDTH-1:0]          data
);

  // A slot granted this cycle drains on the edge, so it may refill at the same time.
  assign in_ready = !full || clear;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full <= 1'b0;
      rd   <= '0;
      data <= '0;
    end else if (in_valid && in_ready) begin
      full <= 1'b1;
      rd   <= in_rd;
      data <= in_data;
    end else if (clear) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - round-robin arbiter sharing the register-file write port
module wb_arbiter #(
  parameter int DATA_WIDTH          = 64,
  parameter int DATA_REG_ADDR_WIDTH = 7,
  parameter int GP_LO               = 4,
  parameter int GP_HI               = 27,
  parameter int CNT_WIDTH           = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           rf_enable,
  input  logic                           alu_valid,
  output logic                           alu_ready,
  input  logic [DATA_REG_ADDR_WIDTH-1:0] alu_rd,
  input  logic [DATA_WIDTH-1:0]          alu_data,
  input  logic                           lsu_valid,
  output logic                           lsu_ready,
  input  logic [DATA_REG_ADDR_WIDTH-1:0] lsu_rd,
  input  logic [DATA_WIDTH-1:0]          lsu_data,
  output logic                           REG_WRITE,
  output logic [DATA_REG_ADDR_WIDTH-1:0] rd,
  output logic [DATA_WIDTH-1:0]          write_data,
  output logic                           ro_err,
  output logic [CNT_WIDTH-1:0]           wb_count,
  output logic                           idle
);
  import wb_pkg::*;

  localparam logic [DATA_REG_ADDR_WIDTH-1:0] LO_A = DATA_REG_ADDR_WIDTH'(GP_LO);
  localparam logic [DATA_REG_ADDR_WIDTH-1:0] HI_A = DATA_REG_ADDR_WIDTH'(GP_HI);

  logic                           alu_full, lsu_full;
  logic                           alu_gnt, lsu_gnt, any_gnt, legal;
  logic [DATA_REG_ADDR_WIDTH-1:0] alu_slot_rd, lsu_slot_rd, sel_rd;
  logic [DATA_WIDTH-1:0]          alu_slot_data, lsu_slot_data, sel_data;
  src_e                           last_grant;

  wb_slot #(.DATA_WIDTH(DATA_WIDTH), .DATA_REG_ADDR_WIDTH(DATA_REG_ADDR_WIDTH)) u_alu_slot (
    .clk(clk), .rst(rst), .in_valid(alu_valid), .in_ready(alu_ready),
    .in_rd(alu_rd), .in_data(alu_data), .clear(alu_gnt),
    .full(alu_full), .rd(alu_slot_rd), .data(alu_slot_data)
  );

  wb_slot #(.DATA_WIDTH(DATA_WIDTH), .DATA_REG_ADDR_WIDTH(DATA_REG_ADDR_WIDTH)) u_lsu_slot (
    .clk(clk), .rst(rst), .in_valid(lsu_valid), .in_ready(lsu_ready),
    .in_rd(lsu_rd), .in_data(lsu_data), .clear(lsu_gnt),
    .full(lsu_full), .rd(lsu_slot_rd), .data(lsu_slot_data)
  );

  // Grant depends only on registered slot state, never on the incoming valids.
  always_comb begin
    alu_gnt = 1'b0;
    lsu_gnt = 1'b0;
    if (rf_enable) begin
      if (alu_full && lsu_full) begin
        alu_gnt = (last_grant == SRC_LSU);
        lsu_gnt = (last_grant == SRC_ALU);
      end else begin
        alu_gnt = alu_full;
        lsu_gnt = lsu_full;
      end
    end
  end

  assign any_gnt  = alu_gnt || lsu_gnt;
  assign sel_rd   = lsu_gnt ? lsu_slot_rd : alu_slot_rd;
  assign sel_data = lsu_gnt ? lsu_slot_data : alu_slot_data;
  assign legal    = (sel_rd >= LO_A) && (sel_rd <= HI_A);
  assign idle     = !alu_full && !lsu_full && !REG_WRITE;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant <= SRC_LSU;
      REG_WRITE  <= 1'b0;
      ro_err     <= 1'b0;
      rd         <= '0;
      write_data <= '0;
      wb_count   <= '0;
    end else begin
      REG_WRITE <= any_gnt && legal;
      ro_err    <= any_gnt && !legal;
      if (any_gnt) last_grant <= lsu_gnt ? SRC_LSU : SRC_ALU;
      if (any_gnt && legal) begin
        rd         <= sel_rd;
        write_data <= sel_data;
        wb_count   <= wb_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - randomized scoreboard bench for wb_arbiter
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rf_enable = 1'b0;
  logic        alu_valid = 1'b0, lsu_valid = 1'b0;
  logic        alu_ready, lsu_ready;
  logic [6:0]  alu_rd = '0, lsu_rd = '0;
  logic [63:0] alu_data = '0, lsu_data = '0;
  logic        REG_WRITE, ro_err, idle;
  logic [6:0]  rd;
  logic [63:0] write_data;
  logic [15:0] wb_count;

  wb_arbiter dut (
    .clk(clk), .rst(rst), .rf_enable(rf_enable),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .REG_WRITE(REG_WRITE), .rd(rd), .write_data(write_data), .ro_err(ro_err),
    .wb_count(wb_count), .idle(idle)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rw;
    logic        err;
    logic [6:0]  rd;
    logic [63:0] data;
    logic [15:0] cnt;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int fails  = 0;

  // Reference model state: pending entry per source plus the port's visible state.
  bit          m_ap, m_lp, m_last_lsu, m_rw;
  logic [6:0]  m_ard, m_lrd, m_rd;
  logic [63:0] m_ad, m_ld, m_data;
  logic [15:0] m_cnt;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_ap = 0; m_lp = 0; m_last_lsu = 1; m_rw = 0;
    m_ard = '0; m_lrd = '0; m_ad = '0; m_ld = '0;
    m_rd = '0; m_data = '0; m_cnt = '0;
    q.delete();
  endtask

  task automatic check_reset_values();
    chk("rst_reg_write", REG_WRITE, 0);
    chk("rst_rd", rd, 0);
    chk("rst_write_data", write_data, 0);
    chk("rst_ro_err", ro_err, 0);
    chk("rst_wb_count", wb_count, 0);
    chk("rst_alu_ready", alu_ready, 1);
    chk("rst_lsu_ready", lsu_ready, 1);
    chk("rst_idle", idle, 1);
  endtask

  task automatic rand_inputs();
    rf_enable = 1'($urandom); alu_valid = 1'($urandom); lsu_valid = 1'($urandom);
    alu_rd = 7'($urandom); lsu_rd = 7'($urandom);
    alu_data = {$urandom, $urandom}; lsu_data = {$urandom, $urandom};
  endtask

  task automatic do_reset(int n);
    @(negedge clk);
    rst = 1'b0;
    rand_inputs();
    model_clear();
    #1 check_reset_values();
    repeat (n) begin
      @(negedge clk);
      rand_inputs();
      #1 check_reset_values();
    end
    @(negedge clk);
    rst = 1'b1;
    rf_enable = 1'b1; alu_valid = 1'b0; lsu_valid = 1'b0;
  endtask

  // One cycle: drive inputs, predict the next-edge result from the rules, advance the model.
  task automatic step(bit rfe, bit av, logic [6:0] ard, logic [63:0] ad,
                      bit lv, logic [6:0] lrd, logic [63:0] ld);
    bit ga, gl, ar, lr;
    exp_t e;
    logic [6:0] srd;
    logic [63:0] sdata;
    @(negedge clk);
    rf_enable = rfe; alu_valid = av; alu_rd = ard; alu_data = ad;
    lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
    ga = 0; gl = 0;
    if (rfe) begin
      if (m_ap && m_lp) begin ga = m_last_lsu; gl = !m_last_lsu; end
      else begin ga = m_ap; gl = m_lp; end
    end
    ar = !m_ap || ga;
    lr = !m_lp || gl;
    #1;
    chk("alu_ready", alu_ready, ar);
    chk("lsu_ready", lsu_ready, lr);
    chk("idle", idle, !m_ap && !m_lp && !m_rw);
    e.rw = 0; e.err = 0;
    if (ga || gl) begin
      srd   = gl ? m_lrd : m_ard;
      sdata = gl ? m_ld : m_ad;
      m_last_lsu = gl;
      if (srd >= 4 && srd <= 27) begin
        e.rw = 1; m_rd = srd; m_data = sdata; m_cnt = m_cnt + 16'd1;
      end else begin
        e.err = 1;
      end
    end
    e.rd = m_rd; e.data = m_data; e.cnt = m_cnt;
    q.push_back(e);
    m_rw = e.rw;
    if (ga) m_ap = 0;
    if (gl) m_lp = 0;
    if (av && ar) begin m_ap = 1; m_ard = ard; m_ad = ad; end
    if (lv && lr) begin m_lp = 1; m_lrd = lrd; m_ld = ld; end
  endtask

  task automatic idle_cycles(int n);
    repeat (n) step(1, 0, '0, '0, 0, '0, '0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        if (q.size() == 0) begin
          chk("unexpected_output", {REG_WRITE, ro_err}, 2'b00);
        end else begin
          e = q.pop_front();
          chk("reg_write", REG_WRITE, e.rw);
          chk("ro_err", ro_err, e.err);
          chk("rd", rd, e.rd);
          chk("write_data", write_data, e.data);
          chk("wb_count", wb_count, e.cnt);
        end
      end
    end
  end

  initial begin : driver
    model_clear();
    do_reset(3);
    idle_cycles(3);

    step(1, 1, 7'd5, 64'hDEAD, 0, '0, '0);
    idle_cycles(3);

    do_reset(1);
    repeat (10) step(1, 1, 7'd6, {$urandom, $urandom}, 1, 7'd7, {$urandom, $urandom});
    idle_cycles(3);

    step(0, 1, 7'd8, 64'h8888, 1, 7'd9, 64'h9999);
    repeat (5) step(0, 0, '0, '0, 0, '0, '0);
    idle_cycles(3);

    step(1, 0, '0, '0, 1, 7'd2, 64'h2222);
    step(1, 1, 7'd30, 64'h3030, 0, '0, '0);
    step(1, 1, 7'd4, 64'h4444, 0, '0, '0);
    idle_cycles(3);

    step(0, 1, 7'd10, 64'hA0, 1, 7'd11, 64'hB0);
    step(0, 0, '0, '0, 0, '0, '0);
    do_reset(2);
    idle_cycles(3);

    repeat (2000) step($urandom_range(0, 4) != 0, 1'($urandom), 7'($urandom_range(0, 31)),
                       {$urandom, $urandom}, 1'($urandom), 7'($urandom_range(0, 31)),
                       {$urandom, $urandom});
    idle_cycles(4);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Write-back arbiter that shares the per-lane register file's single write port between the ALU and load/store unit (LSU) result paths. Each source hands over results through a valid/ready handshake into a one-entry holding slot. A round-robin arbiter with a fairness bound drives the registered write-port signals, which connect directly to the register file's write controls. The block also enforces read-only register protection and counts committed writes.

## Interface
- DATA_WIDTH, 64, write data width
- DATA_REG_ADDR_WIDTH, 7, destination register address width
- GP_LO, 4, lowest writable register index
- GP_HI, 27, highest writable register index
- CNT_WIDTH, 16, committed-write counter width

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-low reset
- rf_enable  input  1  register-file enable; no grant while low
- alu_valid  input  1  ALU result valid
- alu_ready  output  1  ALU slot can accept
- alu_rd  input  DATA_REG_ADDR_WIDTH  ALU destination
- alu_data  input  DATA_WIDTH  ALU result
- lsu_valid  input  1  LSU result valid
- lsu_ready  output  1  LSU slot can accept
- lsu_rd  input  DATA_REG_ADDR_WIDTH  LSU destination
- lsu_data  input  DATA_WIDTH  LSU load data
- REG_WRITE  output  1  write strobe to register file
- rd  output  DATA_REG_ADDR_WIDTH  write address
- write_data  output  DATA_WIDTH  write data
- ro_err  output  1  one-cycle pulse: a protected-register write was dropped
- wb_count  output  CNT_WIDTH  committed writes, wraps
- idle  output  1  both slots empty and REG_WRITE low

## Operation
- **Slots:** one entry per source (valid, rd, data). A slot loads on valid&&ready.
  - ready = !slot_full || slot_granted_this_cycle.
  - A slot can be emptied and reloaded on the same edge.
- **Grant:** computed combinationally from slot_full flags, rf_enable and last_grant only, never from *_valid, so there is no combinational loop.
  - No grant while rf_enable=0.
  - Exactly one slot full: grant that slot.
  - Both slots full: grant the source that was not granted last.
- **last_grant:** updates only on a grant. Resets to LSU, so the ALU wins the first tie.
- **Protection:** a granted entry with rd<GP_LO or rd>GP_HI is dropped.
  - The slot empties.
  - REG_WRITE stays 0 on the next cycle.
  - ro_err=1 for that cycle.
  - wb_count is unchanged.
  - A dropped entry still counts as a grant for last_grant.
- **Commit:** a granted legal entry sets REG_WRITE=1, rd, write_data on the next edge for exactly one cycle, and increments wb_count (mod 2^CNT_WIDTH).
- **Output hold:** rd and write_data hold their last value while REG_WRITE=0.
- **Same rd from both sources:** committed in grant order; no merging.
- **Reset mid-operation:** slots and in-flight output are discarded; nothing is replayed.

## Timing
- **Reset values:** REG_WRITE=0, rd=0, write_data=0, ro_err=0, wb_count=0, slots empty, alu_ready=lsu_ready=1, idle=1.
- **Latency:** handshake at edge E → REG_WRITE high in the cycle after edge E+1, provided it is granted immediately.
- **Throughput:** 1 write per cycle aggregate. A single source streaming alone sustains 1 per cycle.
- **Fairness:** under continuous contention, grants alternate ALU/LSU. No source waits more than 1 grant.
- **rf_enable low:** full slots hold, their ready is 0 and nothing is lost. Grants resume on the first cycle rf_enable=1.
- **Registered outputs:** REG_WRITE, rd, write_data, ro_err, wb_count.
- **Combinational outputs:** ready and idle, derived from registered state plus grant.

## Structure
- Package wb_pkg:
  - source encoding (SRC_ALU=0, SRC_LSU=1)
  - default GP_LO/GP_HI constants
  - slot record typedef (valid, rd, data)
- Sub-module wb_slot: one-entry holding register with load/clear and ready generation, instantiated once per source.
- Top level holds the arbiter, protection check, output register and counter.

## Test plan
- **Reset:** assert rst=0 with random inputs → all outputs at their reset values and idle=1; after release, no REG_WRITE until a handshake occurs.
- **Single ALU write:** alu_rd=5, alu_data=0xDEAD handshaked at edge E → REG_WRITE=1 with rd=5, write_data=0xDEAD only in the cycle after E+1; wb_count=1.
- **Contention:** both sources valid every cycle, ALU rd=6, LSU rd=7 → commits 6,7,6,7…; one REG_WRITE per cycle; first commit is 6.
- **Stall:** rf_enable=0 with both slots full for 5 cycles → no REG_WRITE and both ready=0. rf_enable=1 → both entries committed in the next two cycles, in round-robin order.
- **Protection:** LSU rd=2, then ALU rd=30 → both handshakes complete, REG_WRITE stays 0, ro_err pulses twice, wb_count unchanged; a following rd=4 write commits.
- **Reset mid-operation:** rst=0 while both slots are full → slots cleared immediately; after release, no REG_WRITE, wb_count=0, idle=1.
